// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module   : mem_ctrl_pkg
// Brief    : Shared types and constants for the CPU-side memory controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

   localparam int M_ADDR_W = 18;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_WR    = 3'd2,
      ST_IF_LO = 3'd3,
      ST_IF_HI = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      REQ_RD = 2'd0,
      REQ_WR = 2'd1,
      REQ_IF = 2'd2
   } req_t;

   // Instruction beats address 16-bit halves: index*2 + hi, tagged into instruction space.
   function automatic logic [M_ADDR_W-1:0] fetch_addr(input logic [15:0] idx,
                                                      input logic hi,
                                                      input logic [M_ADDR_W-1:0] space_mask);
      return {1'b0, idx, hi} | space_mask;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_if.sv
// ============================================================================
// Module   : mem_ctrl_if
// Brief    : CPU request port plus 16-bit external req/ack memory bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_ctrl_if;
   import mem_ctrl_pkg::*;

   logic [15:0]         c_addr;
   logic [15:0]         c_wdata;
   logic                c_read;
   logic                c_write;
   logic                c_instr;
   logic                c_read_done;
   logic [15:0]         c_rdata;
   logic [31:0]         c_instr_data;
   logic                c_busy;
   logic                c_ready;
   logic [M_ADDR_W-1:0] m_addr;
   logic [15:0]         m_wdata;
   logic                m_req;
   logic                m_we;
   logic [15:0]         m_rdata;
   logic                m_ack;
   logic                err;

   modport slave (
      input  c_addr, c_wdata, c_read, c_write, c_instr, c_read_done, m_rdata, m_ack,
      output c_rdata, c_instr_data, c_busy, c_ready, m_addr, m_wdata, m_req, m_we, err
   );

   modport master (
      output c_addr, c_wdata, c_read, c_write, c_instr, c_read_done, m_rdata, m_ack,
      input  c_rdata, c_instr_data, c_busy, c_ready, m_addr, m_wdata, m_req, m_we, err
   );

endinterface

`default_nettype wire

// File: rtl/mem_ctrl_timeout_cnt.sv
// ============================================================================
// Module   : timeout_cnt
// Brief    : Clearable enable counter flagging LIMIT consecutive enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timeout_cnt #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A LIMIT of zero never fires.
   assign tc_o = (LIMIT > 0) && en_i && !clr_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module   : mem_ctrl
// Brief    : Latches one CPU read/write/fetch and sequences it on a req/ack bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT   = 255,
   parameter int INSTR_BIT = 17
) (
   input logic       clk,
   input logic       rst,
   mem_ctrl_if.slave bus
);

   localparam logic [M_ADDR_W-1:0] INSTR_MASK = {{(M_ADDR_W-1){1'b0}}, 1'b1} << INSTR_BIT;

   state_t              state_q, state_d;
   req_t                type_q, type_d;
   logic [15:0]         addr_q, addr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic [15:0]         rdata_q, rdata_d;
   logic [31:0]         instr_q, instr_d;
   logic                m_req_q, m_req_d;
   logic                err_q, err_d;
   logic                w_beat;
   logic                w_tmo;
   logic                w_busy;
   logic [M_ADDR_W-1:0] w_m_addr;
   logic [15:0]         w_m_wdata;
   logic                w_m_we;

   // An ack only counts while the request is actually on the bus.
   assign w_beat = m_req_q & bus.m_ack;
   assign w_busy = (state_q == ST_RD) || (state_q == ST_WR) ||
                   (state_q == ST_IF_LO) || (state_q == ST_IF_HI);

   timeout_cnt #(
      .LIMIT (TIMEOUT)
   ) u_timeout_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (!m_req_q || w_beat),
      .en_i  (m_req_q),
      .tc_o  (w_tmo)
   );

   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      instr_d = instr_q;
      m_req_d = m_req_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.c_write) begin
               type_d  = REQ_WR;
               state_d = ST_WR;
            end else if (bus.c_read && bus.c_instr) begin
               type_d  = REQ_IF;
               state_d = ST_IF_LO;
            end else if (bus.c_read) begin
               type_d  = REQ_RD;
               state_d = ST_RD;
            end
            if (bus.c_write || bus.c_read) begin
               addr_d  = bus.c_addr;
               wdata_d = bus.c_wdata;
               m_req_d = 1'b1;
            end
         end
         ST_RD, ST_WR, ST_IF_LO, ST_IF_HI: begin
            if (w_beat) begin
               m_req_d = 1'b0;
               state_d = ST_DONE;
               if (state_q == ST_RD) begin
                  rdata_d = bus.m_rdata;
               end
               if (state_q == ST_IF_LO) begin
                  instr_d[15:0] = bus.m_rdata;
                  state_d       = ST_IF_HI;
               end
               if (state_q == ST_IF_HI) begin
                  instr_d[31:16] = bus.m_rdata;
               end
            end else if (w_tmo) begin
               m_req_d = 1'b0;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (!m_req_q) begin
               // First IF_HI cycle: the request was dropped after the low beat.
               m_req_d = 1'b1;
            end
         end
         ST_DONE: begin
            if ((type_q == REQ_WR) || bus.c_read_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            m_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         type_q  <= REQ_RD;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         instr_q <= '0;
         m_req_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         instr_q <= instr_d;
         m_req_q <= m_req_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      w_m_addr  = '0;
      w_m_wdata = '0;
      w_m_we    = 1'b0;
      unique case (state_q)
         ST_RD:    w_m_addr = {2'b00, addr_q};
         ST_WR: begin
            w_m_addr  = {2'b00, addr_q};
            w_m_wdata = wdata_q;
            w_m_we    = 1'b1;
         end
         ST_IF_LO: w_m_addr = fetch_addr(addr_q, 1'b0, INSTR_MASK);
         ST_IF_HI: w_m_addr = fetch_addr(addr_q, 1'b1, INSTR_MASK);
         default:  w_m_addr = '0;
      endcase
   end

   assign bus.m_addr       = w_m_addr;
   assign bus.m_wdata      = w_m_wdata;
   assign bus.m_we         = w_m_we;
   assign bus.m_req        = m_req_q;
   assign bus.c_busy       = w_busy;
   assign bus.c_ready      = (state_q == ST_DONE);
   assign bus.c_rdata      = rdata_q;
   assign bus.c_instr_data = instr_q;
   assign bus.err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Directed table-driven bench for mem_ctrl with a cycle-level memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   typedef struct {
      bit          rd;
      bit          wr;
      bit          ins;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] d_lo;
      logic [15:0] d_hi;
      int          lat;
      logic [17:0] exp_lo;
      logic [17:0] exp_hi;
      bit          exp_we;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [15:0] mdl_rdata = '0;
   logic [31:0] mdl_instr = '0;
   vec_t vecs[7];

   always #5 clk = ~clk;

   mem_ctrl_if bus();

   mem_ctrl #(
      .TIMEOUT   (8),
      .INSTR_BIT (17)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.c_addr      = '0;
      bus.c_wdata     = '0;
      bus.c_read      = 1'b0;
      bus.c_write     = 1'b0;
      bus.c_instr     = 1'b0;
      bus.c_read_done = 1'b0;
      bus.m_rdata     = '0;
      bus.m_ack       = 1'b0;
   endtask

   task automatic wait_req(input string name, inout int cyc);
      int k = 0;
      while (bus.m_req !== 1'b1 && k < 32) begin
         @(negedge clk);
         k++;
         cyc++;
      end
      if (bus.m_req !== 1'b1) chk({name, " req wait expired"}, 32'd0, 32'd1);
   endtask

   task automatic do_beat(input int lat, input logic [15:0] d, inout int cyc);
      repeat (lat) begin
         @(negedge clk);
         cyc++;
      end
      bus.m_ack   = 1'b1;
      bus.m_rdata = d;
      @(negedge clk);
      cyc++;
      bus.m_ack   = 1'b0;
      bus.m_rdata = '0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      int    cyc;
      bit    is_if;
      tag   = $sformatf("v%0d", idx);
      is_if = !v.wr && v.rd && v.ins;
      @(negedge clk);
      bus.c_addr  = v.addr;
      bus.c_wdata = v.wdata;
      bus.c_read  = v.rd;
      bus.c_write = v.wr;
      bus.c_instr = v.ins;
      @(negedge clk);
      cyc = 1;
      idle_inputs();
      chk({tag, " m_req"}, 32'(bus.m_req), 32'd1);
      chk({tag, " busy"}, 32'(bus.c_busy), 32'd1);
      chk({tag, " m_addr"}, 32'(bus.m_addr), 32'(v.exp_lo));
      chk({tag, " m_we"}, 32'(bus.m_we), 32'(v.exp_we));
      if (v.exp_we) chk({tag, " m_wdata"}, 32'(bus.m_wdata), 32'(v.wdata));
      do_beat(v.lat, v.d_lo, cyc);
      if (is_if) begin
         chk({tag, " beat gap"}, 32'(bus.m_req), 32'd0);
         @(negedge clk);
         cyc++;
         wait_req(tag, cyc);
         chk({tag, " hi addr"}, 32'(bus.m_addr), 32'(v.exp_hi));
         do_beat(v.lat, v.d_hi, cyc);
      end
      chk({tag, " ready"}, 32'(bus.c_ready), 32'd1);
      chk({tag, " req drop"}, 32'(bus.m_req), 32'd0);
      chk({tag, " busy done"}, 32'(bus.c_busy), 32'd0);
      chk({tag, " latency"}, 32'(cyc), is_if ? 32'(2 * v.lat + 4) : 32'(v.lat + 2));
      if (v.wr) begin
         @(negedge clk);
         chk({tag, " ready pulse"}, 32'(bus.c_ready), 32'd0);
         chk({tag, " no read queued"}, 32'(bus.m_req), 32'd0);
      end else begin
         repeat (2) @(negedge clk);
         chk({tag, " ready held"}, 32'(bus.c_ready), 32'd1);
         bus.c_read_done = 1'b1;
         @(negedge clk);
         bus.c_read_done = 1'b0;
         chk({tag, " ready release"}, 32'(bus.c_ready), 32'd0);
         if (is_if) mdl_instr = {v.d_hi, v.d_lo};
         else       mdl_rdata = v.d_lo;
      end
      chk({tag, " c_rdata"}, 32'(bus.c_rdata), 32'(mdl_rdata));
      chk({tag, " c_instr_data"}, bus.c_instr_data, mdl_instr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      int cyc;
      //          rd wr ins addr      wdata     d_lo      d_hi      lat exp_lo      exp_hi      we
      vecs[0] = '{1, 0, 0, 16'h1234, 16'h0000, 16'hBEEF, 16'h0000, 3, 18'h01234, 18'h00000, 0};
      vecs[1] = '{0, 1, 0, 16'h0042, 16'hA5A5, 16'h0000, 16'h0000, 0, 18'h00042, 18'h00000, 1};
      vecs[2] = '{1, 0, 1, 16'h0010, 16'h0000, 16'h1111, 16'h2222, 1, 18'h20020, 18'h20021, 0};
      vecs[3] = '{1, 1, 0, 16'h0077, 16'h5A5A, 16'h0000, 16'h0000, 2, 18'h00077, 18'h00000, 1};
      vecs[4] = '{1, 0, 1, 16'hFFFF, 16'h0000, 16'h3333, 16'h4444, 0, 18'h3FFFE, 18'h3FFFF, 0};
      vecs[5] = '{1, 0, 0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 0, 18'h00000, 18'h00000, 0};
      vecs[6] = '{1, 0, 0, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000, 1, 18'h0FFFF, 18'h00000, 0};

      idle_inputs();
      repeat (3) @(negedge clk);
      chk("reset m_req", 32'(bus.m_req), 32'd0);
      chk("reset busy", 32'(bus.c_busy), 32'd0);
      chk("reset ready", 32'(bus.c_ready), 32'd0);
      chk("reset c_rdata", 32'(bus.c_rdata), 32'd0);
      chk("reset c_instr_data", bus.c_instr_data, 32'd0);
      chk("reset err", 32'(bus.err), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Stray ack with no request outstanding.
      @(negedge clk);
      bus.m_ack   = 1'b1;
      bus.m_rdata = 16'hDEAD;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      chk("stray ack c_rdata", 32'(bus.c_rdata), 32'(mdl_rdata));
      chk("stray ack busy", 32'(bus.c_busy), 32'd0);
      chk("stray ack ready", 32'(bus.c_ready), 32'd0);

      // Unanswered read runs into the timeout.
      bus.c_addr = 16'h0100;
      bus.c_read = 1'b1;
      @(negedge clk);
      idle_inputs();
      hi = 0;
      while (bus.m_req === 1'b1 && hi < 20) begin
         hi++;
         @(negedge clk);
      end
      chk("timeout req cycles", 32'(hi), 32'd8);
      chk("timeout err", 32'(bus.err), 32'd1);
      chk("timeout ready", 32'(bus.c_ready), 32'd1);
      chk("timeout c_rdata", 32'(bus.c_rdata), 32'(mdl_rdata));
      bus.c_read_done = 1'b1;
      @(negedge clk);
      bus.c_read_done = 1'b0;
      chk("timeout release", 32'(bus.c_ready), 32'd0);
      chk("err sticky", 32'(bus.err), 32'd1);

      // Asynchronous reset while the high fetch beat is outstanding.
      bus.c_addr  = 16'h0005;
      bus.c_read  = 1'b1;
      bus.c_instr = 1'b1;
      @(negedge clk);
      idle_inputs();
      cyc = 1;
      do_beat(0, 16'h7777, cyc);
      @(negedge clk);
      chk("if_hi before reset m_req", 32'(bus.m_req), 32'd1);
      chk("if_hi before reset addr", 32'(bus.m_addr), 32'h2000B);
      #2 rst = 1'b0;
      #1;
      chk("async rst m_req", 32'(bus.m_req), 32'd0);
      chk("async rst busy", 32'(bus.c_busy), 32'd0);
      chk("async rst ready", 32'(bus.c_ready), 32'd0);
      chk("async rst m_addr", 32'(bus.m_addr), 32'd0);
      chk("async rst c_rdata", 32'(bus.c_rdata), 32'd0);
      chk("async rst c_instr_data", bus.c_instr_data, 32'd0);
      chk("async rst err", 32'(bus.err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      bus.m_ack   = 1'b1;
      bus.m_rdata = 16'h9999;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      chk("late ack m_req", 32'(bus.m_req), 32'd0);
      chk("late ack c_instr_data", bus.c_instr_data, 32'd0);
      chk("late ack ready", 32'(bus.c_ready), 32'd0);
      chk("late ack busy", 32'(bus.c_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
